// File: rtl/rob_channel_pkg.sv
// rtl/rob_channel_pkg.sv - shared mpc_types package: reorder channel types and defaults
package mpc_types;

    localparam int ROB_NUM_BANKS  = 4;
    localparam int ROB_DATA_W     = 128;
    localparam int ROB_FIFO_DEPTH = 4;

    typedef logic [$clog2(ROB_NUM_BANKS)-1:0] rob_bank_id_t;
    typedef logic [ROB_DATA_W-1:0]            rob_data_t;

endpackage

// File: rtl/rob_bank_fifo.sv
// rtl/rob_bank_fifo.sv - per-bank sync FIFO with wrap-flag pointers and combinational head
module rob_bank_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // MSB is the wrap flag; pointers count modulo 2*DEPTH
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset: emptiness is defined purely by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rob_channel.sv
// rtl/rob_channel.sv - kob-ordered reorder responder; ROB_CHANNEL_BYPASS_EN enables empty-FIFO bypass
module rob_channel
    import mpc_types::*;
#(
    parameter int NUM_BANKS  = ROB_NUM_BANKS,
    parameter int DATA_W     = ROB_DATA_W,
    parameter int FIFO_DEPTH = ROB_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_BANKS-1:0]              bank_rsp_valid,
    output logic [NUM_BANKS-1:0]              bank_rsp_ready,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_rsp_data,
    input  logic                              kob_req,
    input  logic [$clog2(NUM_BANKS)-1:0]      kob_bank_id,
    output logic                              kob_ack,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_W-1:0]                 rsp_data
);

    localparam int ID_W = $clog2(NUM_BANKS);

    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] empty;
    logic [NUM_BANKS-1:0] push;
    logic [NUM_BANKS-1:0] pop;
    logic [DATA_W-1:0]    head [NUM_BANKS];
    logic                 out_free;
    logic                 fifo_ack;
    logic                 bypass;
    logic [DATA_W-1:0]    load_data;

    assign bank_rsp_ready = ~full;
    assign out_free       = ~rsp_valid | rsp_ready;
    assign fifo_ack       = kob_req & ~empty[kob_bank_id] & out_free;

`ifdef ROB_CHANNEL_BYPASS_EN
    // Head bank has nothing buffered but is presenting the beat right now
    assign bypass    = kob_req & empty[kob_bank_id] & bank_rsp_valid[kob_bank_id] & out_free;
    assign load_data = bypass ? bank_rsp_data[kob_bank_id] : head[kob_bank_id];
`else
    assign bypass    = 1'b0;
    assign load_data = head[kob_bank_id];
`endif

    assign kob_ack = fifo_ack | bypass;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic is_head;

        assign is_head = (kob_bank_id == ID_W'(b));
        assign push[b] = bank_rsp_valid[b] & ~full[b] & ~(bypass & is_head);
        assign pop[b]  = fifo_ack & is_head;

        rob_bank_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DATA_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[b]),
            .pop   (pop[b]),
            .wdata (bank_rsp_data[b]),
            .rdata (head[b]),
            .full  (full[b]),
            .empty (empty[b])
        );
    end

    // A reload on kob_ack wins over the clear from a completed handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (kob_ack) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_channel.sv
// tb/tb_rob_channel.sv - scoreboard bench for rob_channel (build with ROB_CHANNEL_BYPASS_EN for bypass)
module tb_rob_channel;

    localparam int NB    = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 4;
`ifdef ROB_CHANNEL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [NB-1:0]          bank_rsp_valid;
    logic [NB-1:0]          bank_rsp_ready;
    logic [NB-1:0][DW-1:0]  bank_rsp_data;
    logic                   kob_req;
    logic [1:0]             kob_bank_id;
    logic                   kob_ack;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DW-1:0]          rsp_data;

    rob_channel #(.NUM_BANKS(NB), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bank_rsp_valid (bank_rsp_valid),
        .bank_rsp_ready (bank_rsp_ready),
        .bank_rsp_data  (bank_rsp_data),
        .kob_req        (kob_req),
        .kob_bank_id    (kob_bank_id),
        .kob_ack        (kob_ack),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference: kob order list, per-bank pending returns, expected delivery order
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] bank_pend [NB][$];
    int            kob_q [$];
    int            cnt [NB];
    bit            ov;
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    bit            ack_seen;
    int            ack_count;
    int            bank_pct = 100;
    int            rdy_mode = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Bank return and channel ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int b = 0; b < NB; b++) begin
                if (bank_pend[b].size() > 0 && $urandom_range(99) < bank_pct) begin
                    bank_rsp_valid[b] = 1'b1;
                    bank_rsp_data[b]  = bank_pend[b][0];
                end else begin
                    bank_rsp_valid[b] = 1'b0;
                    bank_rsp_data[b]  = '0;
                end
            end
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // kob model: presents the oldest outstanding entry, retires it after an ack
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ack_seen && kob_q.size() > 0) void'(kob_q.pop_front());
            ack_seen = 1'b0;
            kob_req     = (kob_q.size() > 0);
            kob_bank_id = (kob_q.size() > 0) ? 2'(kob_q[0]) : 2'd0;
        end
    end

    // Monitor: ack rule, ready rule, output valid model, hold stability, data order
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) cnt[b] = 0;
            ov = 1'b0;
            prev_hold = 1'b0;
            ack_seen = 1'b0;
        end else begin
            int id;
            bit exp_ack;
            bit byp_now;
            logic [NB-1:0] rdy_exp;
            id = int'(kob_bank_id);
            exp_ack = kob_req && (!rsp_valid || rsp_ready) &&
                      (cnt[id] > 0 || (BYP && bank_rsp_valid[id]));
            chk("kob_ack", {127'd0, kob_ack}, {127'd0, exp_ack});
            for (int b = 0; b < NB; b++) rdy_exp[b] = (cnt[b] < DEPTH);
            chk("bank_ready", {124'd0, bank_rsp_ready}, {124'd0, rdy_exp});
            chk("rsp_valid", {127'd0, rsp_valid}, {127'd0, ov});
            if (prev_hold) chk("rsp_hold", rsp_data, prev_data);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_extra actual=%0h required=none at %0t", rsp_data, $time);
                end else begin
                    chk("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
            byp_now = kob_ack && (cnt[id] == 0);
            for (int b = 0; b < NB; b++) begin
                if (bank_rsp_valid[b] && bank_rsp_ready[b]) begin
                    if (!(byp_now && b == id)) cnt[b]++;
                    if (bank_pend[b].size() > 0) void'(bank_pend[b].pop_front());
                end
                if (kob_ack && b == id && !byp_now) cnt[b]--;
            end
            if (kob_ack) ov = 1'b1;
            else if (ov && rsp_ready) ov = 1'b0;
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            if (kob_ack) ack_count++;
            ack_seen = kob_ack;
        end
    end

    task automatic load(input int bank, input logic [DW-1:0] d);
        kob_q.push_back(bank);
        bank_pend[bank].push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", DW'(exp_q.size()), '0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bank_rsp_valid = '0;
        bank_rsp_data  = '0;
        kob_req        = 1'b0;
        kob_bank_id    = '0;
        rsp_ready      = 1'b1;
        #22 rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", {127'd0, rsp_valid}, '0);
            chk("idle_ack", {127'd0, kob_ack}, '0);
            chk("idle_ready", {124'd0, bank_rsp_ready}, 128'hF);
        end
        chk("idle_data", rsp_data, '0);

        // Single load on bank 2
        @(posedge clk);
        load(2, 128'hA5);
        @(negedge clk);
`ifdef ROB_CHANNEL_BYPASS_EN
        chk("single_ack_t", {127'd0, kob_ack}, 128'd1);
        @(negedge clk);
        chk("single_valid_t1", {127'd0, rsp_valid}, 128'd1);
        chk("single_data_t1", rsp_data, 128'hA5);
`else
        chk("single_ack_t", {127'd0, kob_ack}, 128'd0);
        @(negedge clk);
        chk("single_ack_t1", {127'd0, kob_ack}, 128'd1);
        chk("single_valid_t1", {127'd0, rsp_valid}, 128'd0);
        @(negedge clk);
        chk("single_valid_t2", {127'd0, rsp_valid}, 128'd1);
        chk("single_data_t2", rsp_data, 128'hA5);
`endif
        drain(50);

        // Out-of-order: kob wants bank 1 then 3, bank 3 answers first
        @(posedge clk);
        kob_q.push_back(1);
        kob_q.push_back(3);
        exp_q.push_back(128'h11);
        exp_q.push_back(128'h33);
        bank_pend[3].push_back(128'h33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ooo_no_ack", {127'd0, kob_ack}, '0);
            @(posedge clk);
        end
        bank_pend[1].push_back(128'h11);
        drain(50);

        // Backpressure and full-FIFO push/pop on bank 0
        @(posedge clk);
        rdy_mode  = 0;
        ack_count = 0;
        for (int i = 0; i < 6; i++) load(0, DW'(32'h100 + i));
        repeat (12) @(negedge clk);
        chk("bp_single_ack", DW'(ack_count), 128'd1);
        chk("bp_full", {127'd0, bank_rsp_ready[0]}, '0);
        chk("bp_valid", {127'd0, rsp_valid}, 128'd1);
        chk("bp_data", rsp_data, 128'h100);
        @(posedge clk);
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_stream", {127'd0, rsp_valid}, 128'd1);
            if (i == 0) chk("full_push_refused", {127'd0, bank_rsp_ready[0]}, '0);
            if (i == 1) chk("full_occ3_ready", {127'd0, bank_rsp_ready[0]}, 128'd1);
        end
        drain(50);

        // Asynchronous reset with beats buffered in bank 1
        @(posedge clk);
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) load(1, DW'(32'h200 + i));
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {127'd0, rsp_valid}, '0);
        chk("arst_data", rsp_data, '0);
        chk("arst_ready", {124'd0, bank_rsp_ready}, 128'hF);
        chk("arst_empty_ack", {127'd0, kob_ack}, '0);
        exp_q.delete();
        kob_q.delete();
        for (int b = 0; b < NB; b++) bank_pend[b].delete();
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Randomized traffic
        @(posedge clk);
        bank_pct = 50;
        rdy_mode = 2;
        for (int i = 0; i < 80; i++)
            load(int'($urandom_range(NB - 1)), {$urandom, $urandom, $urandom, $urandom});
        drain(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
